// File: rtl/pwm_generator_pkg.sv
// Shared types and constants for the PWM generator.
package pwm_generator_pkg;

  localparam int unsigned WIDTH_DEFAULT = 8;

  typedef logic [WIDTH_DEFAULT-1:0] duty_t;

  localparam duty_t DUTY_ALL_ONES = '1;

endpackage

// File: rtl/pos_edge_flip_flop_async_reset.sv
// Generic rising-edge register with asynchronous active-low clear to zero.
module pos_edge_flip_flop_async_reset #(
  parameter int unsigned BITS = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [BITS-1:0] d,
  output logic [BITS-1:0] q
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= '0;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/pwm_generator.sv
// Free-running counter PWM with registered output and period-start strobe.
// Define PWM_GENERATOR_SHADOW_UPDATE_EN to latch duty only at period boundaries.
module pwm_generator
  import pwm_generator_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] duty_cycle,
  output logic             pwm_out,
  output logic             period_start
);

  localparam logic [WIDTH-1:0] CntMax = '1;

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;
  logic [WIDTH-1:0] duty_act;
  logic             pwm_d;
  logic             period_start_d;

  assign cnt_d = cnt_q + WIDTH'(1'b1);

  pos_edge_flip_flop_async_reset #(
    .BITS (WIDTH)
  ) u_cnt_reg (
    .clk   (clk),
    .reset (reset),
    .d     (cnt_d),
    .q     (cnt_q)
  );

`ifdef PWM_GENERATOR_SHADOW_UPDATE_EN
  logic [WIDTH-1:0] duty_sh_q;
  logic [WIDTH-1:0] duty_sh_d;

  // Reload on the last count so the new duty governs the whole next period.
  assign duty_sh_d = (cnt_q == CntMax) ? duty_cycle : duty_sh_q;

  pos_edge_flip_flop_async_reset #(
    .BITS (WIDTH)
  ) u_duty_sh_reg (
    .clk   (clk),
    .reset (reset),
    .d     (duty_sh_d),
    .q     (duty_sh_q)
  );

  assign duty_act = duty_sh_q;
`else
  assign duty_act = duty_cycle;
`endif

  // All-ones duty would otherwise leave one low cycle per period.
  assign pwm_d          = (duty_act == CntMax) || (cnt_q < duty_act);
  assign period_start_d = (cnt_q == '0);

  pos_edge_flip_flop_async_reset #(
    .BITS (1)
  ) u_pwm_reg (
    .clk   (clk),
    .reset (reset),
    .d     (pwm_d),
    .q     (pwm_out)
  );

  pos_edge_flip_flop_async_reset #(
    .BITS (1)
  ) u_period_start_reg (
    .clk   (clk),
    .reset (reset),
    .d     (period_start_d),
    .q     (period_start)
  );

endmodule

// File: tb/tb_pwm_generator.sv
// Randomized and directed bench for pwm_generator against a period-level reference model.
module tb_pwm_generator;
  import pwm_generator_pkg::*;

  localparam int P    = 1 << WIDTH_DEFAULT;
  localparam int MAXD = P - 1;
`ifdef PWM_GENERATOR_SHADOW_UPDATE_EN
  localparam bit SHADOW = 1'b1;
`else
  localparam bit SHADOW = 1'b0;
`endif

  logic  clk = 1'b0;
  logic  reset = 1'b1;
  duty_t duty_cycle = '0;
  logic  pwm_out;
  logic  period_start;

  always #5 clk = ~clk;

  pwm_generator #(
    .WIDTH (WIDTH_DEFAULT)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .duty_cycle   (duty_cycle),
    .pwm_out      (pwm_out),
    .period_start (period_start)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%h), expected %0d", name, act, act, exp);
    end
  endtask

  // Reference: the k-th edge after reset sits at position (k mod P) of a period;
  // the output is high for the first D positions, or the whole period if D is all-ones.
  function automatic bit level_at(input int pos, input int d);
    return (d == MAXD) || (pos < d);
  endfunction

  int m_edges;
  int m_period_duty;
  bit m_pwm;
  bit m_ps;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_edges       <= 0;
      m_period_duty <= 0;
      m_pwm         <= 1'b0;
      m_ps          <= 1'b0;
    end else begin
      m_pwm <= level_at(m_edges % P, SHADOW ? m_period_duty : int'(duty_cycle));
      m_ps  <= ((m_edges % P) == 0);
      if ((m_edges % P) == MAXD) m_period_duty <= int'(duty_cycle);
      m_edges <= m_edges + 1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("pwm_out_vs_model", 32'(pwm_out), 32'(m_pwm));
      check("period_start_vs_model", 32'(period_start), 32'(m_ps));
    end
  end

  // Statistics over samples taken one half-cycle after each rising edge.
  int s_idx, highs, pss, first_hi, last_hi, ps_a, ps_b;

  task automatic clear_stats();
    highs = 0; pss = 0; first_hi = -1; last_hi = -1; ps_a = -1; ps_b = -1;
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(negedge clk);
      s_idx++;
      if (pwm_out === 1'b1) begin
        highs++;
        if (first_hi < 0) first_hi = s_idx;
        last_hi = s_idx;
      end
      if (period_start === 1'b1) begin
        pss++;
        if (ps_a < 0) ps_a = s_idx;
        else if (ps_b < 0) ps_b = s_idx;
      end
    end
  endtask

  task automatic apply_reset(input int cycles);
    @(negedge clk);
    #2 reset = 1'b0;
    repeat (cycles) @(negedge clk);
    #2 reset = 1'b1;
    s_idx = 0;
  endtask

  initial begin
    #1 reset = 1'b0;
    #1 chk_en = 1'b1;

    // Held reset with a mid-range duty: everything stays low, first edge starts a period.
    duty_cycle = 8'h80;
    clear_stats();
    run(10);
    check("reset_hold_highs", highs, 0);
    check("reset_hold_ps", pss, 0);
    #2 reset = 1'b1;
    s_idx = 0;
    clear_stats();
    run(1);
    check("release_ps", 32'(period_start), 1);
    check("release_pwm", 32'(pwm_out), SHADOW ? 0 : 1);

    // Duty 0: never high, strobe exactly twice 256 cycles apart.
    duty_cycle = 8'h00;
    apply_reset(2);
    clear_stats();
    run(512);
    check("duty0_highs", highs, 0);
    check("duty0_ps_count", pss, 2);
    check("duty0_ps_first", ps_a, 1);
    check("duty0_ps_second", ps_b, 257);

    // Duty 3: three consecutive highs starting in the period_start cycle.
    duty_cycle = 8'd3;
    apply_reset(2);
    clear_stats();
    run(256);
    check("duty3_p1_highs", highs, SHADOW ? 0 : 3);
    check("duty3_p1_first", first_hi, SHADOW ? -1 : 1);
    clear_stats();
    run(256);
    check("duty3_p2_highs", highs, 3);
    check("duty3_p2_first", first_hi, 257);
    check("duty3_p2_last", last_hi, 259);
    check("duty3_p2_ps", ps_a, 257);

    // All-ones duty: constantly high once applied.
    duty_cycle = 8'hFF;
    apply_reset(2);
    clear_stats();
    run(256);
    check("dutyff_p1_highs", highs, SHADOW ? 0 : 256);
    clear_stats();
    run(256);
    check("dutyff_p2_highs", highs, 256);

    // Duty 64 changed to 192 just before the cnt=100 compare.
    duty_cycle = 8'd64;
    apply_reset(2);
    clear_stats();
    run(256);
    check("chg_p1_highs", highs, SHADOW ? 0 : 64);
    clear_stats();
    run(100);
    #2 duty_cycle = 8'd192;
    run(156);
    check("chg_p2_highs", highs, SHADOW ? 64 : 156);
    check("chg_p2_first", first_hi, 257);
    check("chg_p2_last", last_hi, SHADOW ? 320 : 448);
    clear_stats();
    run(256);
    check("chg_p3_highs", highs, 192);
    check("chg_p3_first", first_hi, 513);
    check("chg_p3_last", last_hi, 704);

    // Reset mid-period while high: output drops at once, then a clean period follows.
    duty_cycle = 8'd64;
    apply_reset(2);
    run(256);
    clear_stats();
    run(21);
    check("abort_pre_high", 32'(pwm_out), 1);
    #2 reset = 1'b0;
    #1;
    check("abort_async_pwm", 32'(pwm_out), 0);
    check("abort_async_ps", 32'(period_start), 0);
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    s_idx = 0;
    clear_stats();
    run(256);
    check("abort_p1_highs", highs, SHADOW ? 0 : 64);
    check("abort_p1_ps", ps_a, 1);
    clear_stats();
    run(256);
    check("abort_p2_highs", highs, 64);

    // Random duty updates and occasional async resets, checked against the model.
    apply_reset(1);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      #2;
      case ($urandom_range(0, 15))
        0: duty_cycle = duty_t'($urandom);
        1: duty_cycle = 8'h00;
        2: duty_cycle = 8'hFF;
        3: begin
          if ($urandom_range(0, 39) == 0) begin
            reset = 1'b0;
            #1;
            check("rand_async_pwm", 32'(pwm_out), 0);
            repeat ($urandom_range(1, 3)) @(negedge clk);
            #2 reset = 1'b1;
          end
        end
        default: ;
      endcase
    end

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
